// File: rtl/load_store_unit_pkg.sv
// Shared types, size encodings and lane helpers for the load/store unit.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    // Unsigned variants only make sense for loads.
    function automatic logic size_legal(input logic [2:0] size, input logic is_write);
        case (size)
            SZ_B, SZ_H, SZ_W: size_legal = 1'b1;
            SZ_BU, SZ_HU:     size_legal = !is_write;
            default:          size_legal = 1'b0;
        endcase
    endfunction

    function automatic logic addr_aligned(input logic [2:0] size, input logic [1:0] off);
        case (size[1:0])
            2'b01:   addr_aligned = !off[0];
            2'b10:   addr_aligned = (off == 2'b00);
            default: addr_aligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [2:0] size, input logic [1:0] off);
        case (size[1:0])
            2'b00:   byte_enables = 4'b0001 << off;
            2'b01:   byte_enables = 4'b0011 << {off[1], 1'b0};
            default: byte_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] size, input logic [31:0] data);
        case (size[1:0])
            2'b00:   store_lanes = {4{data[7:0]}};
            2'b01:   store_lanes = {2{data[15:0]}};
            default: store_lanes = data;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Picks the addressed byte/halfword out of a bus word and sign- or zero-extends it.
module load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  size_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

        case (size_i)
            SZ_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            SZ_BU:   data_o = {24'd0, byte_sel};
            SZ_H:    data_o = {{16{half_sel[15]}}, half_sel};
            SZ_HU:   data_o = {16'd0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> REQ -> RESP handshake to a word bus,
// with lane steering, load extension, error detection and an ack timeout.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        mem_size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic              err_q, err_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [2:0]        size_q;
    logic [1:0]        off_q;
    logic              bus_we_q;
    logic [3:0]        bus_be_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [31:0]       bus_wdata_q;
    logic [31:0]       rdata_q;
    logic [31:0]       load_data;

    logic req_any, req_ok, timeout_hit;

    assign req_any     = mem_read | mem_write;
    assign req_ok      = !(mem_read && mem_write)
                         && size_legal(mem_size, mem_write)
                         && addr_aligned(mem_size, addr[1:0]);
    assign timeout_hit = (cnt_q == TO_LAST) && !bus_ack;

    load_align u_load_align (
        .word_i (bus_rdata),
        .off_i  (off_q),
        .size_i (size_q),
        .data_o (load_data)
    );

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    if (req_ok) begin
                        state_d = S_REQ;
                        cnt_d   = '0;
                    end else begin
                        // Rejected requests skip the bus and report straight away.
                        state_d = S_RESP;
                        err_d   = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (bus_ack) begin
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            size_q      <= SZ_W;
            off_q       <= 2'b00;
            bus_we_q    <= 1'b0;
            bus_be_q    <= 4'b0000;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && req_any && req_ok) begin
                size_q      <= mem_size;
                off_q       <= addr[1:0];
                bus_we_q    <= mem_write;
                bus_be_q    <= byte_enables(mem_size, addr[1:0]);
                bus_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                bus_wdata_q <= store_lanes(mem_size, wdata);
            end
            if (state_q == S_REQ && !bus_we_q) begin
                if (bus_ack) begin
                    rdata_q <= load_data;
                end else if (timeout_hit) begin
                    rdata_q <= '0;
                end
            end
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_RESP);
    assign err       = err_q;
    assign bus_req   = (state_q == S_REQ);
    assign bus_we    = bus_we_q;
    assign bus_be    = bus_be_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (timeout shortened to 4 cycles).
module tb_load_store_unit;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    logic        clk, resetn;
    logic        mem_read, mem_write;
    logic [2:0]  mem_size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        busy, done, err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int errors = 0;
    int checks = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .addr(addr), .wdata(wdata), .rdata(rdata),
        .busy(busy), .done(done), .err(err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a one-cycle strobe; returns 1 time unit after the accepting edge.
    task automatic issue(input logic rd, input logic wr, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_size = sz; addr = a; wdata = wd;
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req got=%b want=0", bus_req); end
        checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL reset_bus_we got=%b want=0", bus_we); end
        checks++; if (bus_be !== 4'h0) begin errors++; $display("FAIL reset_bus_be got=%h want=0", bus_be); end
        checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL reset_bus_addr got=%h want=0", bus_addr); end
        checks++; if (bus_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus_wdata got=%h want=0", bus_wdata); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h want=0", rdata); end
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_status got=%b want=000", {busy, done, err}); end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_lw();
        issue(1'b1, 1'b0, SZ_W, 32'h0000_0010, 32'h0);
        checks++; if ({bus_req, busy, done} !== 3'b110) begin errors++; $display("FAIL lw_req_status got=%b want=110", {bus_req, busy, done}); end
        checks++; if (bus_be !== 4'b1111) begin errors++; $display("FAIL lw_be got=%b want=1111", bus_be); end
        checks++; if (bus_addr !== 32'h10) begin errors++; $display("FAIL lw_addr got=%h want=00000010", bus_addr); end
        checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL lw_we got=%b want=0", bus_we); end
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        step();
        bus_ack = 1'b0;
        checks++; if ({done, err, bus_req} !== 3'b100) begin errors++; $display("FAIL lw_done got=%b want=100", {done, err, bus_req}); end
        checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rdata got=%h want=deadbeef", rdata); end
        step();
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL lw_idle got=%b want=00", {busy, done}); end
    endtask

    task automatic test_byte_loads();
        issue(1'b1, 1'b0, SZ_B, 32'h0000_0013, 32'h0);
        checks++; if (bus_be !== 4'b1000) begin errors++; $display("FAIL lb_be got=%b want=1000", bus_be); end
        checks++; if (bus_addr !== 32'h10) begin errors++; $display("FAIL lb_addr got=%h want=00000010", bus_addr); end
        bus_ack = 1'b1; bus_rdata = 32'h8000_0000;
        step();
        bus_ack = 1'b0;
        checks++; if (rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata got=%h want=ffffff80", rdata); end
        step();
        issue(1'b1, 1'b0, SZ_BU, 32'h0000_0013, 32'h0);
        bus_ack = 1'b1; bus_rdata = 32'h8000_0000;
        step();
        bus_ack = 1'b0;
        checks++; if (rdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_rdata got=%h want=00000080", rdata); end
        step();
    endtask

    task automatic test_store_half();
        issue(1'b0, 1'b1, SZ_H, 32'h0000_0102, 32'h0000_1234);
        checks++; if ({bus_req, bus_we} !== 2'b11) begin errors++; $display("FAIL sh_req_we got=%b want=11", {bus_req, bus_we}); end
        checks++; if (bus_be !== 4'b1100) begin errors++; $display("FAIL sh_be got=%b want=1100", bus_be); end
        checks++; if (bus_wdata !== 32'h1234_1234) begin errors++; $display("FAIL sh_wdata got=%h want=12341234", bus_wdata); end
        checks++; if (bus_addr !== 32'h100) begin errors++; $display("FAIL sh_addr got=%h want=00000100", bus_addr); end
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        step();
        bus_ack = 1'b0;
        checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL sh_done got=%b want=10", {done, err}); end
        checks++; if (rdata !== 32'h0000_0080) begin errors++; $display("FAIL sh_rdata_kept got=%h want=00000080", rdata); end
        step();
    endtask

    task automatic test_half_loads();
        issue(1'b1, 1'b0, SZ_H, 32'h0000_0022, 32'h0);
        checks++; if (bus_be !== 4'b1100) begin errors++; $display("FAIL lh_be got=%b want=1100", bus_be); end
        bus_ack = 1'b1; bus_rdata = 32'hABCD_0000;
        step();
        bus_ack = 1'b0;
        checks++; if (rdata !== 32'hFFFF_ABCD) begin errors++; $display("FAIL lh_rdata got=%h want=ffffabcd", rdata); end
        step();
        issue(1'b1, 1'b0, SZ_HU, 32'h0000_0022, 32'h0);
        bus_ack = 1'b1; bus_rdata = 32'hABCD_0000;
        step();
        bus_ack = 1'b0;
        checks++; if (rdata !== 32'h0000_ABCD) begin errors++; $display("FAIL lhu_rdata got=%h want=0000abcd", rdata); end
        step();
    endtask

    task automatic test_wait_states();
        issue(1'b1, 1'b0, SZ_BU, 32'h0000_0041, 32'h0);
        mem_write = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++; if ({bus_req, bus_we, bus_be} !== 6'b10_0010) begin errors++; $display("FAIL wait_hold%0d got=%b want=100010", i, {bus_req, bus_we, bus_be}); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL wait_nodone%0d got=%b want=0", i, done); end
            step();
        end
        bus_ack = 1'b1; bus_rdata = 32'h0000_5A00; mem_write = 1'b0;
        step();
        bus_ack = 1'b0;
        checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL wait_done got=%b want=10", {done, err}); end
        checks++; if (rdata !== 32'h0000_005A) begin errors++; $display("FAIL wait_rdata got=%h want=0000005a", rdata); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wait_idle got=%b want=0", busy); end
    endtask

    task automatic test_errors();
        issue(1'b1, 1'b0, SZ_W, 32'h0000_0101, 32'h0);
        checks++; if ({bus_req, done, err, busy} !== 4'b0111) begin errors++; $display("FAIL misalign_w got=%b want=0111", {bus_req, done, err, busy}); end
        checks++; if (rdata !== 32'h0000_005A) begin errors++; $display("FAIL misalign_rdata got=%h want=0000005a", rdata); end
        step();
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL misalign_after got=%b want=000", {busy, done, err}); end
        issue(1'b1, 1'b0, SZ_H, 32'h0000_0103, 32'h0);
        checks++; if ({bus_req, done, err} !== 3'b011) begin errors++; $display("FAIL misalign_h got=%b want=011", {bus_req, done, err}); end
        step();
        issue(1'b1, 1'b1, SZ_W, 32'h0000_0100, 32'h0);
        checks++; if ({bus_req, done, err} !== 3'b011) begin errors++; $display("FAIL collision got=%b want=011", {bus_req, done, err}); end
        step();
        issue(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0);
        checks++; if ({bus_req, done, err} !== 3'b011) begin errors++; $display("FAIL bad_size got=%b want=011", {bus_req, done, err}); end
        step();
        issue(1'b0, 1'b1, SZ_BU, 32'h0000_0100, 32'h0);
        checks++; if ({bus_req, done, err} !== 3'b011) begin errors++; $display("FAIL store_bu got=%b want=011", {bus_req, done, err}); end
        step();
    endtask

    task automatic test_ack_ignored();
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        step();
        bus_ack = 1'b0;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL idle_ack_status got=%b want=00", {busy, done}); end
        checks++; if (rdata !== 32'h0000_005A) begin errors++; $display("FAIL idle_ack_rdata got=%h want=0000005a", rdata); end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        issue(1'b1, 1'b0, SZ_W, 32'h0000_0020, 32'h0);
        for (int i = 0; i < 10 && !done; i++) begin
            if (bus_req) req_cycles++;
            step();
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL timeout_done got=%b want=1", done); end
        checks++; if (req_cycles !== 4) begin errors++; $display("FAIL timeout_req_cycles got=%0d want=4", req_cycles); end
        checks++; if ({err, bus_req} !== 2'b10) begin errors++; $display("FAIL timeout_err got=%b want=10", {err, bus_req}); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL timeout_rdata got=%h want=00000000", rdata); end
        step();
    endtask

    task automatic test_reset_mid_req();
        issue(1'b1, 1'b0, SZ_W, 32'h0000_0030, 32'h0);
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL midrst_req got=%b want=1", bus_req); end
        #2;
        resetn = 1'b0;
        #1;
        checks++; if ({bus_req, busy} !== 2'b00) begin errors++; $display("FAIL midrst_async got=%b want=00", {bus_req, busy}); end
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL midrst_nodone%0d got=%b want=00", i, {done, busy}); end
        end
        issue(1'b0, 1'b1, SZ_B, 32'h0000_0103, 32'h0000_00A5);
        checks++; if ({bus_req, bus_we, bus_be} !== 6'b11_1000) begin errors++; $display("FAIL sb_ctrl got=%b want=111000", {bus_req, bus_we, bus_be}); end
        checks++; if (bus_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata got=%h want=a5a5a5a5", bus_wdata); end
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL sb_done got=%b want=10", {done, err}); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL sb_rdata got=%h want=00000000", rdata); end
        step();
    endtask

    initial begin
        resetn = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_size = 3'b000;
        addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        test_reset();
        test_lw();
        test_byte_loads();
        test_store_half();
        test_half_loads();
        test_wait_states();
        test_errors();
        test_ack_ignored();
        test_timeout();
        test_reset_mid_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
